// File: rtl/codes_ex_core.sv
// codes_ex_core: Hamming(7,4) encoder with error injection, syndrome decode and single-error correction
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   data_in[3:0]      nibble to encode, sampled with in_valid
//   in_valid          input strobe, one word per cycle, no backpressure
//   err_pos[2:0]      0 = clean, 1..7 = flip codeword position n
//   code_out[6:0]     registered codeword, code_out[n-1] = position n
//   syndrome[2:0]     position of the single error in code_out, 0 if none
//   data_out[3:0]     corrected data nibble
//   err_detected      syndrome is nonzero
//   out_valid         one-cycle pulse per accepted word
module codes_ex_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       in_valid,
  input  logic [2:0] err_pos,
  output logic [6:0] code_out,
  output logic [2:0] syndrome,
  output logic [3:0] data_out,
  output logic       err_detected,
  output logic       out_valid
);
  logic [6:0] enc;
  logic [7:0] inj_oh;
  logic [7:0] fix_oh;
  logic [6:0] fixed;
  assign enc = {data_in[3], data_in[2], data_in[1],
                data_in[1] ^ data_in[2] ^ data_in[3],
                data_in[0],
                data_in[0] ^ data_in[2] ^ data_in[3],
                data_in[0] ^ data_in[1] ^ data_in[3]};
  // One-hot of the position to flip; bit 0 (position "0") is dropped so 0 means no flip.
  assign inj_oh = 8'd1 << err_pos;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) code_out <= enc ^ inj_oh[7:1];
    end
  end
  assign syndrome = {code_out[3] ^ code_out[4] ^ code_out[5] ^ code_out[6],
                     code_out[1] ^ code_out[2] ^ code_out[5] ^ code_out[6],
                     code_out[0] ^ code_out[2] ^ code_out[4] ^ code_out[6]};
  assign fix_oh       = 8'd1 << syndrome;
  assign fixed        = code_out ^ fix_oh[7:1];
  assign data_out     = {fixed[6], fixed[5], fixed[4], fixed[2]};
  assign err_detected = |syndrome;
endmodule

// File: tb/tb_codes_ex_core.sv
// tb_codes_ex_core: vector table, exhaustive sweep, random stream and reset/hold sequences for codes_ex_core
module tb_codes_ex_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in = '0;
  logic       in_valid = 1'b0;
  logic [2:0] err_pos = '0;
  logic [6:0] code_out;
  logic [2:0] syndrome;
  logic [3:0] data_out;
  logic       err_detected;
  logic       out_valid;
  int n_vec = 0;
  int n_bad = 0;

  codes_ex_core dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .err_pos(err_pos),
    .code_out(code_out), .syndrome(syndrome), .data_out(data_out),
    .err_detected(err_detected), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] e;
    logic [6:0] c;
    logic [2:0] s;
    logic [3:0] q;
    logic       x;
  } vec_t;

  // Reference codeword built position by position: data at 3,5,6,7; parity at 2^k covers every position with bit k set.
  function automatic logic [6:0] model(input logic [3:0] d, input logic [2:0] e);
    logic [7:0] w;
    w = '0;
    w[3] = d[0];
    w[5] = d[1];
    w[6] = d[2];
    w[7] = d[3];
    for (int k = 0; k < 3; k++)
      for (int j = 1; j < 8; j++)
        if (j != (1 << k) && ((j >> k) & 1) != 0) w[1 << k] = w[1 << k] ^ w[j];
    if (e != 0) w[e] = ~w[e];
    return w[7:1];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [6:0] c, input logic [2:0] s,
                         input logic [3:0] q, input logic x, input logic v);
    chk({nm, ".code_out"}, int'(code_out), int'(c));
    chk({nm, ".syndrome"}, int'(syndrome), int'(s));
    chk({nm, ".data_out"}, int'(data_out), int'(q));
    chk({nm, ".err_detected"}, int'(err_detected), int'(x));
    chk({nm, ".out_valid"}, int'(out_valid), int'(v));
  endtask

  task automatic drive(input logic [3:0] d, input logic [2:0] e, input logic v);
    data_in = d;
    err_pos = e;
    in_valid = v;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[7];
    logic [6:0] ec;
    logic [3:0] ed;
    logic [2:0] ee;
    logic       v;
    logic [3:0] d;
    logic [2:0] e;
    tbl[0] = '{4'd0,  3'd0, 7'b0000000, 3'd0, 4'd0,  1'b0};
    tbl[1] = '{4'd1,  3'd0, 7'b0000111, 3'd0, 4'd1,  1'b0};
    tbl[2] = '{4'd11, 3'd0, 7'b1010101, 3'd0, 4'd11, 1'b0};
    tbl[3] = '{4'd15, 3'd0, 7'b1111111, 3'd0, 4'd15, 1'b0};
    tbl[4] = '{4'd1,  3'd5, 7'b0010111, 3'd5, 4'd1,  1'b1};
    tbl[5] = '{4'd15, 3'd3, 7'b1111011, 3'd3, 4'd15, 1'b1};
    tbl[6] = '{4'd0,  3'd7, 7'b1000000, 3'd7, 4'd0,  1'b1};

    @(negedge clk);
    chk_all("reset", 7'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].d, tbl[i].e, 1'b1);
      chk_all($sformatf("tbl%0d", i), tbl[i].c, tbl[i].s, tbl[i].q, tbl[i].x, 1'b1);
    end

    for (int i = 0; i < 128; i++) begin
      d = i[3:0];
      e = i[6:4];
      drive(d, e, 1'b1);
      chk_all($sformatf("sweep d%0d e%0d", d, e), model(d, e), e, d, e != 0, 1'b1);
    end

    drive(4'd6, 3'd2, 1'b1);
    ec = model(4'd6, 3'd2);
    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 9), 3'(i + 4), 1'b0);
      chk_all($sformatf("hold%0d", i), ec, 3'd2, 4'd6, 1'b1, 1'b0);
    end

    ec = code_out;
    ed = data_out;
    ee = syndrome;
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 3) != 0;
      d = 4'($urandom);
      e = 3'($urandom);
      drive(d, e, v);
      if (v) begin
        ec = model(d, e);
        ed = d;
        ee = e;
      end
      chk_all($sformatf("rand%0d", i), ec, ee, ed, ee != 0, v);
    end

    drive(4'd5, 3'd1, 1'b1);
    data_in = 4'd3;
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 7'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("reset_held", 7'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    data_in = 4'd15;
    err_pos = 3'd0;
    in_valid = 1'b1;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all("after_reset", 7'b1111111, 3'd0, 4'd15, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
